or1200_keccak_feeder: RTL and testbench
=======================================

# or1200_keccak_feeder

Adapter between the OR1200 EX stage and the Keccak core, sitting directly downstream of the `l.cust5` decode path. It accepts decoded custom-5 commands carrying rA data, and buffers message words in a small FIFO. It streams those words into the core's word interface under `buffer_full` backpressure, latches the 512-bit digest, and returns digest words to the register-file write path for store ops.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: message word buffer depth (power of 2, ≥2).
- `DIGEST_W`, 512: core digest width; 16 readable 32-bit words.

Ports. Clock is `clk`. Reset is `rst`, asynchronous, active-high.
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `cmd_valid` in 1: `l.cust5` present in EX and EX not frozen.
- `cmd_op` in 5: insn[4:0].
- `cmd_limm` in 6: insn[10:5].
- `cmd_data` in 32: rA operand.
- `cmd_stall` out 1: freeze request to the pipeline; the command is not accepted while high.
- `rd_valid` out 1: the accepted command produced a result.
- `rd_data` out 32: result for the `rf_dataw` mux.
- `k_reset` out 1: one-cycle core reset pulse.
- `k_in` out 32: data word to the core.
- `k_in_ready` out 1: word valid to the core.
- `k_is_last` out 1: final word to the core.
- `k_byte_num` out 2: valid bytes in the final word.
- `k_buffer_full` in 1: core backpressure.
- `k_out` in 512: digest from the core.
- `k_out_ready` in 1: digest valid from the core.
- `busy` out 1: state is ABSORB or WAIT.
- `digest_valid` out 1: the digest register holds a result.
- `err` out 1: sticky protocol error.

## Operation
Op codes:
- INIT=00000
- END=00001
- MIDDLE=00010
- START=00100
- STORE=01000
- SSTORE=10000
- Any other code is a no-op: accepted, no effect, `rd_valid`=0.

States:
- IDLE
- ABSORB
- WAIT
- DONE

Command behaviour:
- **INIT**, any state:
  - flush FIFO
  - pulse `k_reset` for 1 cycle
  - clear `digest_valid` and `err`
  - go to IDLE
- **START** in IDLE/DONE: push {`cmd_data`, last=0}, go to ABSORB. START in ABSORB is treated as MIDDLE.
- **MIDDLE** in ABSORB: push {`cmd_data`, last=0}.
- **END** in ABSORB: push {`cmd_data`, last=1, bytes=`cmd_limm[1:0]`}, go to WAIT.
- **MIDDLE/END** in IDLE/WAIT/DONE: dropped; set `err`.
- **STORE**: `rd_data` = digest[32*i+31:32*i], with i=`cmd_limm[3:0]`.
- **SSTORE**: same word, byte-reversed.
- **STORE/SSTORE** in IDLE with no digest: return 0, no stall.

Drain: when the FIFO is non-empty and `k_buffer_full`=0, drive the head onto `k_in`/`k_is_last`/`k_byte_num`, assert `k_in_ready`, and pop.

Capture:
- In WAIT, once the FIFO is empty, the first cycle of `k_out_ready`=1 latches `k_out`.
- Then set `digest_valid` and go to DONE.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - FIFO empty
  - digest register 0
- `cmd_stall` is combinational in either of these cases:
  - a push op while the FIFO is full
  - STORE/SSTORE while in ABSORB or WAIT
- A command is accepted on `cmd_valid & ~cmd_stall` at the rising edge.
- `rd_data`/`rd_valid` are combinational in the accept cycle.
- A word accepted at edge N is visible on `k_in` from cycle N+1 (registered FIFO).
- Drain rate is 1 word per cycle with no bubbles.
- Simultaneous push and pop on a full FIFO is not allowed: a full FIFO stalls the push.
- Simultaneous push and pop on a non-full FIFO is allowed; occupancy is unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`.
- INIT coincident with `k_out_ready`: INIT wins, nothing is latched.
- `k_reset` goes high in the cycle after INIT is accepted.
- Async `rst` mid-message discards all state immediately.

## Structure
- Package `keccak_feed_pkg` holds:
  - op code constants
  - the state enum
  - a FIFO entry struct {data[31:0], last, bytes[1:0]}
- Sub-module `keccak_word_fifo`: synchronous FIFO, parameterised depth and width, with full/empty flags.
- Top level: FSM, push/pop logic, digest register, readout mux.

## Test plan
1. **Basic digest.** Sequence: INIT, START 1, MIDDLE 2..6, END 7 with limm=1; stub core raises `k_out_ready` with `k_out`=512'h0..0F..F. Required:
   - 7 words appear on `k_in` in order
   - the last one has `k_is_last`=1, `k_byte_num`=1
   - STORE limm 15..0 returns the matching words
2. **Backpressure.**
   - Hold `k_buffer_full`=1 during 6 pushes: `cmd_stall` rises on the 5th push (FIFO full).
   - Release it: 4 words drain on consecutive cycles, and the stall clears the cycle after the first pop.
3. **Early store.** STORE issued while in WAIT → `cmd_stall`=1 until digest capture; `rd_valid` in the next cycle with the correct word.
4. **SSTORE.** Digest word 0 = 0x11223344 → SSTORE limm 0 returns 0x44332211.
5. **Protocol error and mid-message INIT.**
   - MIDDLE in IDLE → `err`=1, nothing on `k_in`.
   - INIT during ABSORB with 3 words queued → FIFO empty, a 1-cycle `k_reset`, `err`=0, state IDLE.
6. **Async reset.** `rst` asserted between clock edges mid-WAIT → all outputs 0 immediately; a following STORE returns 0 with no stall.

Source files
------------

// File: rtl/keccak_feed_pkg.sv
// Shared definitions for the OR1200 custom-5 to Keccak feeder: command codes,
// controller states, the buffered message word format and a byte-swap helper.
package keccak_feed_pkg;

    localparam logic [4:0] OP_INIT   = 5'b00000;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_SSTORE = 5'b10000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_WAIT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  bytes;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/or1200_keccak_feeder_if.sv
// Command/result bundle from the EX stage plus the Keccak core word interface.
// The feeder takes the slave view; the pipeline and core environment the master view.
interface or1200_keccak_feeder_if #(
    parameter int DIGEST_W = 512
) ();

    logic                cmd_valid;
    logic [4:0]          cmd_op;
    logic [5:0]          cmd_limm;
    logic [31:0]         cmd_data;
    logic                cmd_stall;
    logic                rd_valid;
    logic [31:0]         rd_data;

    logic                k_reset;
    logic [31:0]         k_in;
    logic                k_in_ready;
    logic                k_is_last;
    logic [1:0]          k_byte_num;
    logic                k_buffer_full;
    logic [DIGEST_W-1:0] k_out;
    logic                k_out_ready;

    logic                busy;
    logic                digest_valid;
    logic                err;

    modport slave (
        input  cmd_valid, cmd_op, cmd_limm, cmd_data,
        output cmd_stall, rd_valid, rd_data,
        output k_reset, k_in, k_in_ready, k_is_last, k_byte_num,
        input  k_buffer_full, k_out, k_out_ready,
        output busy, digest_valid, err
    );

    modport master (
        output cmd_valid, cmd_op, cmd_limm, cmd_data,
        input  cmd_stall, rd_valid, rd_data,
        input  k_reset, k_in, k_in_ready, k_is_last, k_byte_num,
        output k_buffer_full, k_out, k_out_ready,
        input  busy, digest_valid, err
    );

endinterface

// File: rtl/keccak_word_fifo.sv
// Synchronous FIFO with registered storage and an occupancy counter.
// DEPTH must be a power of two so the pointers wrap naturally.
module keccak_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
    localparam logic [AW:0]   COUNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE    = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the counter guarantees stale entries are never presented as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/or1200_keccak_feeder.sv
// Bridges l.cust5 commands to the Keccak core: buffers message words, streams
// them under backpressure, captures the digest and serves it back as words.
module or1200_keccak_feeder
    import keccak_feed_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIGEST_W   = 512
) (
    input logic                   clk,
    input logic                   rst,
    or1200_keccak_feeder_if.slave bus
);

    localparam int N_WORDS = DIGEST_W / 32;
    typedef logic [N_WORDS-1:0][31:0] digest_t;

    state_e      state_q, state_d;
    digest_t     digest_q, digest_d;
    logic        digest_valid_q, digest_valid_d;
    logic        err_q, err_d;
    logic        k_reset_q;

    fifo_entry_t push_entry, head;
    logic        fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic        is_push_op, is_store_op, in_flight, accept;
    logic [31:0] store_word;

    keccak_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // START outside WAIT always opens or continues a message; MIDDLE/END only extend one.
    assign in_flight   = (state_q == ST_ABSORB) || (state_q == ST_WAIT);
    assign is_store_op = (bus.cmd_op == OP_STORE) || (bus.cmd_op == OP_SSTORE);
    assign is_push_op  = ((bus.cmd_op == OP_START) && (state_q != ST_WAIT)) ||
                         (((bus.cmd_op == OP_MIDDLE) || (bus.cmd_op == OP_END)) &&
                          (state_q == ST_ABSORB));
    assign bus.cmd_stall = bus.cmd_valid &&
                           ((is_push_op && fifo_full) || (is_store_op && in_flight));
    assign accept        = bus.cmd_valid && !bus.cmd_stall;
    assign store_word    = digest_valid_q ? digest_q[bus.cmd_limm[3:0]] : 32'h0;

    assign fifo_pop       = !fifo_empty && !bus.k_buffer_full;
    assign bus.k_in_ready = fifo_pop;
    assign bus.k_in       = fifo_pop ? head.data : 32'h0;
    assign bus.k_is_last  = fifo_pop & head.last;
    assign bus.k_byte_num = fifo_pop ? head.bytes : 2'b00;

    assign bus.k_reset      = k_reset_q;
    assign bus.busy         = in_flight;
    assign bus.digest_valid = digest_valid_q;
    assign bus.err          = err_q;

    always_comb begin
        state_d        = state_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        err_d          = err_q;
        fifo_push      = 1'b0;
        fifo_flush     = 1'b0;
        push_entry     = '0;
        bus.rd_valid   = 1'b0;
        bus.rd_data    = 32'h0;

        if ((state_q == ST_WAIT) && fifo_empty && bus.k_out_ready) begin
            digest_d       = bus.k_out;
            digest_valid_d = 1'b1;
            state_d        = ST_DONE;
        end

        if (accept) begin
            case (bus.cmd_op)
                // INIT overrides a coincident capture, so nothing is latched.
                OP_INIT: begin
                    fifo_flush     = 1'b1;
                    digest_d       = digest_q;
                    digest_valid_d = 1'b0;
                    err_d          = 1'b0;
                    state_d        = ST_IDLE;
                end
                OP_START, OP_MIDDLE, OP_END: begin
                    if (is_push_op) begin
                        fifo_push       = 1'b1;
                        push_entry.data = bus.cmd_data;
                        if (bus.cmd_op == OP_END) begin
                            push_entry.last  = 1'b1;
                            push_entry.bytes = bus.cmd_limm[1:0];
                            state_d          = ST_WAIT;
                        end else begin
                            state_d = ST_ABSORB;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_STORE: begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = store_word;
                end
                OP_SSTORE: begin
                    bus.rd_valid = 1'b1;
                    bus.rd_data  = byte_swap(store_word);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            err_q          <= 1'b0;
            k_reset_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            err_q          <= err_d;
            k_reset_q      <= accept && (bus.cmd_op == OP_INIT);
        end
    end

endmodule

// File: tb/tb_or1200_keccak_feeder.sv
// Directed bench for the custom-5 Keccak feeder with a stub core and a k_in
// word monitor; expected values are hand-computed constants.
module tb_or1200_keccak_feeder;
    import keccak_feed_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    or1200_keccak_feeder_if bus ();

    or1200_keccak_feeder #(
        .FIFO_DEPTH (4),
        .DIGEST_W   (512)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  bytes;
        int          cyc;
    } beat_t;
    beat_t beats[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.k_in_ready) beats.push_back('{bus.k_in, bus.k_is_last, bus.k_byte_num, cyc});
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] data,
                        output int stalls, output logic rv, output logic [31:0] rdat);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_limm  = limm;
        bus.cmd_data  = data;
        stalls = 0;
        #1;
        while (bus.cmd_stall && stalls < 40) begin
            @(posedge clk);
            #2;
            stalls++;
        end
        if (stalls >= 40) check("stall_bound", bus.cmd_stall, 0);
        rv   = bus.rd_valid;
        rdat = bus.rd_data;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic put(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] data);
        int          s;
        logic        v;
        logic [31:0] d;
        send(op, limm, data, s, v, d);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int                 s;
        logic               v;
        logic [31:0]        d;
        logic [34:0]        exp_beat;
        logic [15:0][31:0]  kw;

        rst               = 1'b1;
        bus.cmd_valid     = 1'b0;
        bus.cmd_op        = 5'h0;
        bus.cmd_limm      = 6'h0;
        bus.cmd_data      = 32'h0;
        bus.k_buffer_full = 1'b0;
        bus.k_out         = '0;
        bus.k_out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_cmd_stall",    bus.cmd_stall, 0);
        check("rst_rd_valid",     bus.rd_valid, 0);
        check("rst_k_reset",      bus.k_reset, 0);
        check("rst_k_in_ready",   bus.k_in_ready, 0);
        check("rst_k_in",         bus.k_in, 0);
        check("rst_busy",         bus.busy, 0);
        check("rst_digest_valid", bus.digest_valid, 0);
        check("rst_err",          bus.err, 0);
        rst = 1'b0;
        tick(1);

        // 1. Basic digest
        put(OP_INIT, 0, 0);
        check("t1_k_reset_hi", bus.k_reset, 1);
        tick(1);
        check("t1_k_reset_lo", bus.k_reset, 0);
        beats.delete();
        put(OP_START, 0, 32'd1);
        for (int i = 2; i <= 6; i++) put(OP_MIDDLE, 0, 32'(i));
        put(OP_END, 6'd1, 32'd7);
        check("t1_busy", bus.busy, 1);
        tick(3);
        check("t1_beat_count", beats.size(), 7);
        for (int i = 0; i < 7 && i < beats.size(); i++) begin
            exp_beat = {32'(i + 1), (i == 6), (i == 6) ? 2'd1 : 2'd0};
            check($sformatf("t1_beat%0d", i), {beats[i].data, beats[i].last, beats[i].bytes}, exp_beat);
        end
        bus.k_out       = {256'h0, {256{1'b1}}};
        bus.k_out_ready = 1'b1;
        tick(1);
        bus.k_out_ready = 1'b0;
        check("t1_digest_valid", bus.digest_valid, 1);
        check("t1_not_busy", bus.busy, 0);
        for (int i = 15; i >= 0; i--) begin
            send(OP_STORE, 6'(i), 0, s, v, d);
            check($sformatf("t1_store%0d", i), {v, d}, {1'b1, (i < 8) ? 32'hFFFF_FFFF : 32'h0});
        end

        // 2. Backpressure
        put(OP_INIT, 0, 0);
        bus.k_buffer_full = 1'b1;
        beats.delete();
        put(OP_START, 0, 32'h100);
        put(OP_MIDDLE, 0, 32'h101);
        put(OP_MIDDLE, 0, 32'h102);
        put(OP_MIDDLE, 0, 32'h103);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_MIDDLE;
        bus.cmd_data  = 32'h104;
        #1;
        check("t2_stall_full", bus.cmd_stall, 1);
        @(posedge clk);
        #2;
        check("t2_stall_hold", bus.cmd_stall, 1);
        check("t2_no_drain", bus.k_in_ready, 0);
        bus.k_buffer_full = 1'b0;
        #1;
        check("t2_stall_pop_cycle", bus.cmd_stall, 1);
        check("t2_first_word", {bus.k_in_ready, bus.k_in}, {1'b1, 32'h100});
        @(posedge clk);
        #1;
        check("t2_stall_clear", bus.cmd_stall, 0);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        put(OP_MIDDLE, 0, 32'h105);
        tick(8);
        check("t2_beat_count", beats.size(), 6);
        for (int i = 0; i < 6 && i < beats.size(); i++) begin
            check($sformatf("t2_word%0d", i), beats[i].data, 32'h100 + 32'(i));
            if (i > 0) check($sformatf("t2_gap%0d", i), beats[i].cyc - beats[0].cyc, i);
        end

        // 3. Early store while waiting for the digest
        put(OP_INIT, 0, 0);
        beats.delete();
        put(OP_START, 0, 32'hA);
        put(OP_END, 6'd3, 32'hB);
        for (int i = 0; i < 16; i++) kw[i] = 32'hC0DE_0000 | 32'(i);
        kw[0] = 32'h1122_3344;
        bus.k_out = kw;
        fork
            send(OP_STORE, 6'd5, 0, s, v, d);
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.k_out_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.k_out_ready = 1'b0;
            end
        join
        check("t3_stall_cycles", s, 4);
        check("t3_store5", {v, d}, {1'b1, 32'hC0DE_0005});
        check("t3_digest_valid", bus.digest_valid, 1);
        check("t3_beat_count", beats.size(), 2);
        if (beats.size() >= 2)
            check("t3_last_beat", {beats[1].data, beats[1].last, beats[1].bytes}, {32'hB, 1'b1, 2'd3});

        // 4. Byte-reversed store
        send(OP_SSTORE, 6'd0, 0, s, v, d);
        check("t4_sstore0", {v, d}, {1'b1, 32'h4433_2211});
        send(OP_STORE, 6'd0, 0, s, v, d);
        check("t4_store0", {v, d}, {1'b1, 32'h1122_3344});
        send(OP_SSTORE, 6'd15, 0, s, v, d);
        check("t4_sstore15", {v, d}, {1'b1, 32'h0F00_DEC0});

        // 5. Protocol error and mid-message INIT
        put(OP_INIT, 0, 0);
        check("t5_err_cleared", bus.err, 0);
        beats.delete();
        send(OP_MIDDLE, 0, 32'h55, s, v, d);
        check("t5_err_set", bus.err, 1);
        check("t5_no_result", v, 0);
        tick(3);
        check("t5_nothing_streamed", beats.size(), 0);
        check("t5_idle", bus.busy, 0);
        bus.k_buffer_full = 1'b1;
        put(OP_START, 0, 32'h1);
        put(OP_MIDDLE, 0, 32'h2);
        put(OP_MIDDLE, 0, 32'h3);
        check("t5_busy", bus.busy, 1);
        put(OP_INIT, 0, 0);
        check("t5_k_reset_hi", bus.k_reset, 1);
        check("t5_err_after_init", bus.err, 0);
        check("t5_idle_after_init", bus.busy, 0);
        tick(1);
        check("t5_k_reset_lo", bus.k_reset, 0);
        bus.k_buffer_full = 1'b0;
        tick(3);
        check("t5_flushed", beats.size(), 0);

        // 6. Async reset mid-WAIT
        put(OP_MIDDLE, 0, 32'h9);
        put(OP_START, 0, 32'h10);
        put(OP_END, 0, 32'h11);
        tick(1);
        check("t6_busy_pre", bus.busy, 1);
        check("t6_err_pre", bus.err, 1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_err", bus.err, 0);
        check("t6_digest_valid", bus.digest_valid, 0);
        check("t6_k_reset", bus.k_reset, 0);
        check("t6_k_in_ready", bus.k_in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1);
        send(OP_STORE, 6'd3, 0, s, v, d);
        check("t6_store_no_stall", s, 0);
        check("t6_store_zero", {v, d}, {1'b1, 32'h0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
